// File: rtl/pipe_scoreboard.sv
// Hazard-detection and forwarding scoreboard for a MIPS back end of any depth and load latency.
// Optional macro PIPE_SCB_PERF_EN adds stall_cycles/stall_events performance counters.
module pipe_scoreboard #(
   parameter  int RA_W     = 5,
   parameter  int DEPTH    = 4,
   parameter  int LOAD_LAT = 1,
   localparam int FW       = $clog2(DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            flush,
   output logic            stall,
   output logic [FW-1:0]   fwd_a,
   output logic [FW-1:0]   fwd_b
`ifdef PIPE_SCB_PERF_EN
   ,
   output logic [31:0]     stall_cycles,
   output logic [31:0]     stall_events
`endif
);

   logic [DEPTH:1]  r_valid;
   logic [DEPTH:1]  r_isLoad;
   logic [RA_W-1:0] r_rd [1:DEPTH];

   logic            w_hazA;
   logic            w_hazB;
   logic [FW-1:0]   w_selA;
   logic [FW-1:0]   w_selB;
   logic            w_stall;
   logic            w_advance;
   logic            w_insert;

   // Scan oldest-to-youngest so the youngest matching producer is the one that sticks;
   // the WB entry is left out because the register file already writes it early.
   function automatic logic [FW:0] scanSrc(input logic [RA_W-1:0] src, input logic useSrc);
      logic          haz;
      logic [FW-1:0] sel;
      int            ready;
      haz   = 1'b0;
      sel   = '0;
      ready = 0;
      for (int j = DEPTH - 1; j >= 1; j--) begin
         if (useSrc && (src != '0) && r_valid[j] && (r_rd[j] == src)) begin
            ready = r_isLoad[j] ? (2 + LOAD_LAT) : 2;
            haz   = (ready > j + 1);
            sel   = (ready > j + 1) ? '0 : FW'(j + 1);
         end
      end
      return {haz, sel};
   endfunction

   always_comb begin
      {w_hazA, w_selA} = scanSrc(id_rs, id_use_rs);
      {w_hazB, w_selB} = scanSrc(id_rt, id_use_rt);
   end

   assign w_stall   = id_valid & ~flush & (w_hazA | w_hazB);
   assign w_advance = id_valid & ~flush & ~w_stall;
   assign w_insert  = w_advance & id_reg_write & (id_rd != '0);
   assign stall     = w_stall;

   // Valid/load flags and forwarding selects; a bubble in EX always selects the register file.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid  <= '0;
         r_isLoad <= '0;
         fwd_a    <= '0;
         fwd_b    <= '0;
      end else begin
         for (int i = DEPTH; i >= 2; i--) begin
            r_valid[i]  <= r_valid[i-1];
            r_isLoad[i] <= r_isLoad[i-1];
         end
         r_valid[1]  <= w_insert;
         r_isLoad[1] <= w_insert & id_mem_read;
         fwd_a       <= w_advance ? w_selA : '0;
         fwd_b       <= w_advance ? w_selB : '0;
      end
   end

   // Destination addresses are qualified by r_valid, so they need no reset.
   always_ff @(posedge clock) begin
      for (int i = DEPTH; i >= 2; i--) begin
         r_rd[i] <= r_rd[i-1];
      end
      r_rd[1] <= id_rd;
   end

`ifdef PIPE_SCB_PERF_EN
   logic r_prevStall;

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
         stall_events <= '0;
         r_prevStall  <= 1'b0;
      end else begin
         r_prevStall <= w_stall;
         if (w_stall) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (w_stall && !r_prevStall) begin
            stall_events <= stall_events + 32'd1;
         end
      end
   end
`endif

endmodule
